// File: rtl/lcd_bus_arbiter.sv
// Round-robin arbiter sharing one 8080-style LCD write bus between two byte-stream requesters.
// Whole bursts are granted; the block times the wr strobe and acknowledges each byte.
module lcd_bus_arbiter #(
    parameter int unsigned WR_LOW_CYC  = 1,
    parameter int unsigned WR_HIGH_CYC = 1
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [1:0] req,
    input  logic [1:0] byte_valid,
    input  logic [7:0] byte_data0,
    input  logic [7:0] byte_data1,
    input  logic [1:0] byte_dcx,
    input  logic [1:0] byte_last,
    output logic [1:0] grant,
    output logic [1:0] byte_ack,
    output logic       busy,
    output logic       wr,
    output logic       dcx,
    output logic       csx,
    output logic [7:0] D
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WR_LO = 2'd2,
        WR_HI = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             owner;
    logic             last_served;
    logic             last_byte;
    logic             pick;

    // On a tie the requester not served most recently wins.
    always_comb begin
        pick = req[1];
        if (req == 2'b11) begin
            pick = ~last_served;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state       <= IDLE;
            cnt         <= '0;
            owner       <= 1'b0;
            last_served <= 1'b1;
            last_byte   <= 1'b0;
            grant       <= 2'b00;
            byte_ack    <= 2'b00;
            busy        <= 1'b0;
            wr          <= 1'b1;
            dcx         <= 1'b1;
            csx         <= 1'b1;
            D           <= 8'h00;
        end else begin
            byte_ack <= 2'b00;
            case (state)
                IDLE: begin
                    if (|req) begin
                        owner <= pick;
                        grant <= pick ? 2'b10 : 2'b01;
                        csx   <= 1'b0;
                        busy  <= 1'b1;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (byte_valid[owner]) begin
                        D         <= owner ? byte_data1 : byte_data0;
                        dcx       <= byte_dcx[owner];
                        last_byte <= byte_last[owner];
                        wr        <= 1'b0;
                        byte_ack  <= grant;
                        cnt       <= CNT_W'(WR_LOW_CYC);
                        state     <= WR_LO;
                    end
                end
                WR_LO: begin
                    if (cnt == CNT_W'(1)) begin
                        wr    <= 1'b1;
                        cnt   <= CNT_W'(WR_HIGH_CYC);
                        state <= WR_HI;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                WR_HI: begin
                    if (cnt == CNT_W'(1)) begin
                        if (last_byte) begin
                            grant       <= 2'b00;
                            csx         <= 1'b1;
                            busy        <= 1'b0;
                            last_served <= owner;
                            state       <= IDLE;
                        end else begin
                            state <= GRANT;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter: one instance with default strobe timing,
// one with WR_LOW_CYC=3 / WR_HIGH_CYC=2, both driven from the same inputs.
module tb_lcd_bus_arbiter;

    logic       clk = 1'b0;
    logic       nrst;
    logic [1:0] req;
    logic [1:0] byte_valid;
    logic [7:0] byte_data0;
    logic [7:0] byte_data1;
    logic [1:0] byte_dcx;
    logic [1:0] byte_last;

    logic [1:0] grant_a, ack_a, grant_b, ack_b;
    logic       busy_a, wr_a, dcx_a, csx_a, busy_b, wr_b, dcx_b, csx_b;
    logic [7:0] d_a, d_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lcd_bus_arbiter dut_a (
        .clk(clk), .nrst(nrst), .req(req), .byte_valid(byte_valid),
        .byte_data0(byte_data0), .byte_data1(byte_data1), .byte_dcx(byte_dcx),
        .byte_last(byte_last), .grant(grant_a), .byte_ack(ack_a), .busy(busy_a),
        .wr(wr_a), .dcx(dcx_a), .csx(csx_a), .D(d_a)
    );

    lcd_bus_arbiter #(.WR_LOW_CYC(3), .WR_HIGH_CYC(2)) dut_b (
        .clk(clk), .nrst(nrst), .req(req), .byte_valid(byte_valid),
        .byte_data0(byte_data0), .byte_data1(byte_data1), .byte_dcx(byte_dcx),
        .byte_last(byte_last), .grant(grant_b), .byte_ack(ack_b), .busy(busy_b),
        .wr(wr_b), .dcx(dcx_b), .csx(csx_b), .D(d_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full bus snapshot of the default-timing instance; busy tracks grant ownership.
    task automatic exp_a(input string tag, input logic [1:0] g, input logic [1:0] a,
                         input logic w, input logic cs, input logic [7:0] d, input logic dc);
        chk({tag, ".grant"}, 32'(grant_a), 32'(g));
        chk({tag, ".ack"},   32'(ack_a),   32'(a));
        chk({tag, ".busy"},  32'(busy_a),  32'(|g));
        chk({tag, ".wr"},    32'(wr_a),    32'(w));
        chk({tag, ".csx"},   32'(csx_a),   32'(cs));
        chk({tag, ".D"},     32'(d_a),     32'(d));
        chk({tag, ".dcx"},   32'(dcx_a),   32'(dc));
    endtask

    task automatic clear_inputs();
        req        = 2'b00;
        byte_valid = 2'b00;
        byte_data0 = 8'h00;
        byte_data1 = 8'h00;
        byte_dcx   = 2'b11;
        byte_last  = 2'b00;
    endtask

    // Two reset cycles with random inputs, then release with quiet inputs.
    task automatic do_reset(input string tag);
        nrst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req        = 2'($urandom);
            byte_valid = 2'($urandom);
            byte_data0 = 8'($urandom);
            byte_data1 = 8'($urandom);
            byte_dcx   = 2'($urandom);
            byte_last  = 2'($urandom);
            tick();
        end
        exp_a(tag, 2'b00, 2'b00, 1'b1, 1'b1, 8'h00, 1'b1);
        chk({tag, ".b_wr"},  32'(wr_b),  32'd1);
        chk({tag, ".b_csx"}, 32'(csx_b), 32'd1);
        clear_inputs();
        nrst = 1'b1;
    endtask

    initial begin
        nrst = 1'b0;
        clear_inputs();
        tick();

        // 1: reset values
        do_reset("rst");

        // 2: three-byte burst on requester 0
        req = 2'b01; byte_valid = 2'b01; byte_data0 = 8'h2C; byte_dcx = 2'b10; byte_last = 2'b00;
        tick(); exp_a("b0.grant", 2'b01, 2'b00, 1'b1, 1'b0, 8'h00, 1'b1);
        tick(); exp_a("b0.byte0", 2'b01, 2'b01, 1'b0, 1'b0, 8'h2C, 1'b0);
        req = 2'b00; byte_data0 = 8'hAB; byte_dcx = 2'b11;
        tick(); exp_a("b0.hi0",   2'b01, 2'b00, 1'b1, 1'b0, 8'h2C, 1'b0);
        tick(); exp_a("b0.gap0",  2'b01, 2'b00, 1'b1, 1'b0, 8'h2C, 1'b0);
        tick(); exp_a("b0.byte1", 2'b01, 2'b01, 1'b0, 1'b0, 8'hAB, 1'b1);
        byte_data0 = 8'hCD; byte_last = 2'b01;
        tick(); exp_a("b0.hi1",   2'b01, 2'b00, 1'b1, 1'b0, 8'hAB, 1'b1);
        tick(); exp_a("b0.gap1",  2'b01, 2'b00, 1'b1, 1'b0, 8'hAB, 1'b1);
        tick(); exp_a("b0.byte2", 2'b01, 2'b01, 1'b0, 1'b0, 8'hCD, 1'b1);
        byte_valid = 2'b00; byte_last = 2'b00;
        tick(); exp_a("b0.hi2",   2'b01, 2'b00, 1'b1, 1'b0, 8'hCD, 1'b1);
        tick(); exp_a("b0.done",  2'b00, 2'b00, 1'b1, 1'b1, 8'hCD, 1'b1);

        // 3: contention, one-byte bursts alternate 01,10,01,10 with an IDLE cycle between
        do_reset("rst3");
        req = 2'b11; byte_valid = 2'b11; byte_data0 = 8'h11; byte_data1 = 8'h22;
        byte_dcx = 2'b11; byte_last = 2'b11;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] g;
            logic [7:0] d;
            g = (i % 2 == 0) ? 2'b01 : 2'b10;
            d = (i % 2 == 0) ? 8'h11 : 8'h22;
            tick(); chk($sformatf("rr%0d.grant", i), 32'(grant_a), 32'(g));
                    chk($sformatf("rr%0d.ack0", i),  32'(ack_a),   32'd0);
            tick(); chk($sformatf("rr%0d.ack", i),   32'(ack_a),   32'(g));
                    chk($sformatf("rr%0d.D", i),     32'(d_a),     32'(d));
                    chk($sformatf("rr%0d.wr", i),    32'(wr_a),    32'd0);
            tick(); chk($sformatf("rr%0d.ack1", i),  32'(ack_a),   32'd0);
            tick(); chk($sformatf("rr%0d.idle", i),  32'(grant_a), 32'd0);
                    chk($sformatf("rr%0d.csx", i),   32'(csx_a),   32'd1);
        end
        clear_inputs();

        // 4: stall with byte_valid low for five cycles after the first ack
        do_reset("rst4");
        req = 2'b01; byte_valid = 2'b01; byte_data0 = 8'h5A; byte_dcx = 2'b11;
        tick(); exp_a("st.grant", 2'b01, 2'b00, 1'b1, 1'b0, 8'h00, 1'b1);
        tick(); exp_a("st.byte0", 2'b01, 2'b01, 1'b0, 1'b0, 8'h5A, 1'b1);
        byte_valid = 2'b00; req = 2'b00;
        for (int i = 0; i < 5; i++) begin
            tick(); exp_a($sformatf("st.wait%0d", i), 2'b01, 2'b00, 1'b1, 1'b0, 8'h5A, 1'b1);
        end
        byte_valid = 2'b01; byte_data0 = 8'hA5; byte_last = 2'b01;
        tick(); exp_a("st.byte1", 2'b01, 2'b01, 1'b0, 1'b0, 8'hA5, 1'b1);
        byte_valid = 2'b00; byte_last = 2'b00;
        tick(); exp_a("st.hi1",   2'b01, 2'b00, 1'b1, 1'b0, 8'hA5, 1'b1);
        tick(); exp_a("st.done",  2'b00, 2'b00, 1'b1, 1'b1, 8'hA5, 1'b1);

        // 5: stretched strobe (3 low, 2 high) on the second instance
        do_reset("rst5");
        req = 2'b01; byte_valid = 2'b01; byte_data0 = 8'h96; byte_dcx = 2'b11;
        tick(); chk("tp.grant", 32'(grant_b), 32'd1);
        for (int b = 0; b < 2; b++) begin
            logic [7:0] d;
            d = (b == 0) ? 8'h96 : 8'h69;
            for (int k = 0; k < 6; k++) begin
                tick();
                chk($sformatf("tp%0d.%0d.wr", b, k),  32'(wr_b),  (k < 3) ? 32'd0 : 32'd1);
                chk($sformatf("tp%0d.%0d.D", b, k),   32'(d_b),   32'(d));
                chk($sformatf("tp%0d.%0d.ack", b, k), 32'(ack_b), (k == 0) ? 32'd1 : 32'd0);
                if (k == 0) begin
                    req = 2'b00;
                    if (b == 0) begin
                        byte_data0 = 8'h69; byte_last = 2'b01;
                    end else begin
                        byte_valid = 2'b00; byte_last = 2'b00;
                    end
                end
            end
        end
        chk("tp.done.grant", 32'(grant_b), 32'd0);
        chk("tp.done.csx",   32'(csx_b),   32'd1);

        // 6: reset while requester 1 strobes its second byte; requester 0 wins afterwards
        do_reset("rst6");
        req = 2'b10; byte_valid = 2'b10; byte_data1 = 8'h31; byte_dcx = 2'b01;
        tick(); exp_a("ab.grant", 2'b10, 2'b00, 1'b1, 1'b0, 8'h00, 1'b1);
        tick(); exp_a("ab.byte0", 2'b10, 2'b10, 1'b0, 1'b0, 8'h31, 1'b0);
        req = 2'b00; byte_data1 = 8'h32;
        tick(); tick();
        tick(); exp_a("ab.byte1", 2'b10, 2'b10, 1'b0, 1'b0, 8'h32, 1'b0);
        nrst = 1'b0; req = 2'b11; byte_valid = 2'b00;
        tick(); exp_a("ab.rst",   2'b00, 2'b00, 1'b1, 1'b1, 8'h00, 1'b1);
        nrst = 1'b1;
        tick(); exp_a("ab.regrant", 2'b01, 2'b00, 1'b1, 1'b0, 8'h00, 1'b1);
        clear_inputs();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_bus_arbiter.md
Name: lcd_bus_arbiter

Overview:
Shares the single 8080-style parallel LCD write bus (wr, dcx, csx, D[7:0]) between two byte-stream requesters. Requester 0 is the pixel updater path inside the image generator; requester 1 is the score/overlay text writer. The block arbitrates whole bursts round-robin, owns the wr strobe timing, and hands back a per-byte acknowledge. It sits between the requesters and the LCD pins.

Parameters:
WR_LOW_CYC, 1, cycles wr is held low per byte (legal 1..15)
WR_HIGH_CYC, 1, cycles wr is held high after the rising edge, with D/dcx held (legal 1..15)

Ports:
clk  input  1  system clock
nrst  input  1  synchronous active-low reset
req  input  2  burst request per requester; sampled only in IDLE
byte_valid  input  2  requester n presents a byte
byte_data0  input  8  byte from requester 0
byte_data1  input  8  byte from requester 1
byte_dcx  input  2  per-requester dcx for the presented byte (0 = command, 1 = data)
byte_last  input  2  presented byte ends the burst
grant  output  2  one-hot burst ownership; 0 when idle
byte_ack  output  2  one-cycle pulse: presented byte consumed
busy  output  1  state != IDLE
wr  output  1  LCD write strobe, active low; LCD latches on the rising edge
dcx  output  1  LCD data/command select
csx  output  1  LCD chip select, active low
D  output  8  LCD data bus

Behaviour:
- One clock. Reset is synchronous, active-low, and overrides everything. Reset values: grant=0, byte_ack=0, busy=0, wr=1, dcx=1, csx=1, D=0x00, state=IDLE, last_served=1 (requester 0 wins the first tie).
- All outputs are registered.
- States: IDLE, GRANT, WR_LO, WR_HI. A 4-bit down-counter times WR_LO and WR_HI.
- IDLE:
  - With exactly one req bit set, grant that requester.
  - With both set, grant the requester != last_served.
  - On the grant edge: grant becomes one-hot, csx=0, go to GRANT. Latency from req sampled to grant visible is 1 cycle.
- GRANT (owner g):
  - When byte_valid[g]=1, on the same edge: D<=byte_data_g, dcx<=byte_dcx[g], latch byte_last[g], wr<=0, byte_ack[g]<=1 for one cycle, counter<=WR_LOW_CYC, go to WR_LO.
  - When byte_valid[g]=0, stay in GRANT: wr=1, csx=0, grant held, no ack.
- WR_LO: hold wr=0 for exactly WR_LOW_CYC cycles. Then wr<=1, counter<=WR_HIGH_CYC, go to WR_HI.
- WR_HI: hold wr=1 with D and dcx unchanged for WR_HIGH_CYC cycles. Then:
  - If the latched last=1: grant<=0, csx<=1, last_served<=g, go to IDLE.
  - Otherwise go to GRANT.
- Byte period with byte_valid held high is 1+WR_LOW_CYC+WR_HIGH_CYC cycles (3 with defaults).
- Burst-to-burst gap: 1 IDLE cycle minimum.
- A requester may change its byte on the cycle after its ack. It must hold byte_valid/data/dcx/last stable until acked.
- req is ignored outside IDLE. Dropping req mid-burst does not end the burst; only an acked byte with byte_last ends it.
- byte_valid from the non-granted requester is ignored and never acked.
- D and dcx keep their last values in IDLE and GRANT; only wr and csx define bus activity.
- Reset mid-burst aborts immediately: next cycle all outputs are at reset values and any partial LCD command is abandoned. The wr rise caused by the abort is permitted; the LCD owner re-initialises the panel.

Test Plan:
1. Reset: hold nrst=0 for 2 cycles with random inputs -> grant=00, byte_ack=00, busy=0, wr=1, dcx=1, csx=1, D=0x00.
2. Single burst on requester 0, defaults, req0=1, bytes 0x2C (dcx=0), 0xAB, 0xCD (last), byte_valid held:
   - grant=01 one cycle after req.
   - csx=0 throughout the burst.
   - Three 1-cycle wr-low pulses spaced 3 cycles apart, with D=0x2C/0xAB/0xCD and dcx=0/1/1.
   - Three byte_ack[0] pulses.
   - Afterwards grant=00, csx=1, busy=0.
3. Contention: req=11 continuously, 1-byte bursts -> grant order 01,10,01,10, each separated by one IDLE cycle. byte_valid[1] asserted during requester 0's burst gets no ack.
4. Stall: requester 0 drops byte_valid for 5 cycles after its first ack -> wr stays 1, csx stays 0, grant=01, no ack. The burst resumes with the next byte one cycle after byte_valid returns.
5. Timing params WR_LOW_CYC=3, WR_HIGH_CYC=2, 2-byte burst -> wr low exactly 3 cycles per byte, D stable for 5 cycles after each wr fall, byte period 6 cycles.
6. Reset during WR_LO of requester 1's second byte, with req=11 pending after release -> outputs at reset values on the next cycle. After release, requester 0 is granted first (last_served reset to 1).
